// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states,
// register-name indices and small op-decoding helpers.
package mult_div_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;

    // Register-file names used by the surrounding core.
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_AT   = 5'd1;
    localparam logic [4:0] REG_V0   = 5'd2;
    localparam logic [4:0] REG_V1   = 5'd3;
    localparam logic [4:0] REG_A0   = 5'd4;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_FP   = 5'd30;
    localparam logic [4:0] REG_RA   = 5'd31;

    function automatic logic op_is_div(input mdu_op_e op_i);
        return op_i[1];
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op_i);
        return ~op_i[0];
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// 64-bit conditional two's-complement: passes the input through unless
// i_en is set, in which case it returns the negated value.
module mdu_negate (
    input  logic        i_en,
    input  logic [63:0] i_data,
    output logic [63:0] o_data
);

    assign o_data = i_en ? (~i_data + 64'd1) : i_data;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Sign handling is done on magnitudes: conditioned at accept, fixed up in FIX.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  r_state;
    mdu_state_e  w_state_next;
    logic [4:0]  r_count;
    mdu_op_e     r_op;
    logic [63:0] r_acc;
    logic [31:0] r_b;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic        r_zero_pend;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_div_zero;

    mdu_op_e     w_op;
    logic        w_in_div;
    logic        w_in_signed;
    logic        w_rt_zero;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [63:0] w_mag_a;
    logic [63:0] w_mag_b;

    assign w_op        = mdu_op_e'(op);
    assign w_in_div    = op_is_div(w_op);
    assign w_in_signed = op_is_signed(w_op);
    assign w_rt_zero   = (rt_data == 32'd0);
    assign w_neg_a     = w_in_signed & rs_data[31];
    assign w_neg_b     = w_in_signed & rt_data[31];

    // Sign-extend only negatives so the upper half of each magnitude is zero.
    mdu_negate u_mag_a (
        .i_en   (w_neg_a),
        .i_data ({{32{w_neg_a}}, rs_data}),
        .o_data (w_mag_a)
    );

    mdu_negate u_mag_b (
        .i_en   (w_neg_b),
        .i_data ({{32{w_neg_b}}, rt_data}),
        .o_data (w_mag_b)
    );

    // Shift-add multiply step: r_acc = {partial product high, remaining multiplier}.
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Restoring divide step: r_acc = {partial remainder, dividend / quotient bits}.
    logic [32:0] w_div_rem_sh;
    logic [32:0] w_div_diff;
    logic        w_div_ge;
    logic [63:0] w_div_next;

    assign w_div_rem_sh = r_acc[63:31];
    assign w_div_diff   = w_div_rem_sh - {1'b0, r_b};
    assign w_div_ge     = ~w_div_diff[32];
    assign w_div_next   = {(w_div_ge ? w_div_diff[31:0] : w_div_rem_sh[31:0]),
                           r_acc[30:0], w_div_ge};

    logic [63:0] w_fix_main;
    logic [63:0] w_fix_rem;

    mdu_negate u_fix_main (
        .i_en   (r_neg_res),
        .i_data (op_is_div(r_op) ? {32'd0, r_acc[31:0]} : r_acc),
        .o_data (w_fix_main)
    );

    mdu_negate u_fix_rem (
        .i_en   (r_neg_rem),
        .i_data ({32'd0, r_acc[63:32]}),
        .o_data (w_fix_rem)
    );

    logic w_unused;
    assign w_unused = ^{w_mag_a[63:32], w_mag_b[63:32], w_fix_rem[63:32]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (w_in_div && w_rt_zero) ? ST_FIX : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_count == 5'd31) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_FIX:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count     <= 5'd0;
            r_op        <= OP_MULT;
            r_acc       <= 64'd0;
            r_b         <= 32'd0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_zero_pend <= 1'b0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op        <= w_op;
                        r_count     <= 5'd0;
                        r_acc       <= {32'd0, (w_in_div ? w_mag_a[31:0] : w_mag_b[31:0])};
                        r_b         <= w_in_div ? w_mag_b[31:0] : w_mag_a[31:0];
                        r_neg_res   <= w_neg_a ^ w_neg_b;
                        r_neg_rem   <= w_in_div & w_neg_a;
                        r_zero_pend <= w_in_div & w_rt_zero;
                    end else begin
                        if (mthi) begin
                            r_hi <= rs_data;
                        end
                        if (mtlo) begin
                            r_lo <= rs_data;
                        end
                    end
                end
                ST_RUN: begin
                    r_acc   <= op_is_div(r_op) ? w_div_next : w_mul_next;
                    r_count <= r_count + 5'd1;
                end
                ST_FIX: begin
                    r_done     <= 1'b1;
                    r_div_zero <= r_zero_pend;
                    // A divide-by-zero reports completion but leaves HI/LO alone.
                    if (!r_zero_pend) begin
                        if (op_is_div(r_op)) begin
                            r_hi <= w_fix_rem[31:0];
                            r_lo <= w_fix_main[31:0];
                        end else begin
                            r_hi <= w_fix_main[63:32];
                            r_lo <= w_fix_main[31:0];
                        end
                    end
                end
                default: begin
                    r_count <= 5'd0;
                end
            endcase
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
